// File: rtl/mod_switches_db.sv
// Debounced switch/button peripheral: 2-flop sync + per-channel debounce, sticky edge flags, maskable irq.
// Optional macro MOD_SWITCHES_DB_RAW_EN exposes the synchronised raw inputs at register 11.

module mod_switches_db_lane #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic s2,
    output logic state,
    output logic ev
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s1;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // a change is accepted once s2 has disagreed with state for DEBOUNCE_CYCLES edges in a row
    assign accept = (s2 != state) && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == state) begin
                cnt <= '0;
            end else if (accept) begin
                state <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

    generate
        if (EDGE_MODE == 0) begin : g_rise
            assign ev = accept & s2;
        end else if (EDGE_MODE == 1) begin : g_fall
            assign ev = accept & ~s2;
        end else begin : g_both
            assign ev = accept;
        end
    endgenerate
endmodule

module mod_switches_db #(
    parameter int N               = 8,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ie,
    input  logic         de,
    input  logic [31:0]  iaddr,
    input  logic [31:0]  daddr,
    input  logic [1:0]   drw,
    input  logic [31:0]  din,
    output logic [31:0]  iout,
    output logic [31:0]  dout,
    input  logic [N-1:0] switches,
    output logic         irq
);
    logic [N-1:0] s2;
    logic [N-1:0] state;
    logic [N-1:0] ev;
    logic [N-1:0] edge_q;
    logic [N-1:0] mask_q;
    logic [N-1:0] clr;
    logic         wr;
    logic [31:0]  state_w, edge_w, mask_w;
    logic         unused_ok;

    for (genvar i = 0; i < N; i++) begin : g_lane
        mod_switches_db_lane #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .raw  (switches[i]),
            .s2   (s2[i]),
            .state(state[i]),
            .ev   (ev[i])
        );
    end

    assign wr  = de & drw[0];
    assign clr = (wr && daddr[3:2] == 2'b01) ? din[N-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
            mask_q <= '0;
        end else begin
            // a new event on a bit being cleared in the same cycle keeps the flag set
            edge_q <= (edge_q & ~clr) | ev;
            if (wr && daddr[3:2] == 2'b10)
                mask_q <= din[N-1:0];
        end
    end

    assign irq  = |(edge_q & mask_q);
    assign iout = '0;

    always_comb begin
        state_w         = '0;
        edge_w          = '0;
        mask_w          = '0;
        state_w[N-1:0]  = state;
        edge_w[N-1:0]   = edge_q;
        mask_w[N-1:0]   = mask_q;
    end

`ifdef MOD_SWITCHES_DB_RAW_EN
    logic [31:0] raw_w;

    always_comb begin
        raw_w        = '0;
        raw_w[N-1:0] = s2;
    end

    always_comb begin
        dout = '0;
        if (de) begin
            case (daddr[3:2])
                2'b00:   dout = state_w;
                2'b01:   dout = edge_w;
                2'b10:   dout = mask_w;
                default: dout = raw_w;
            endcase
        end
    end

    assign unused_ok = ^{ie, iaddr, daddr[31:4], daddr[1:0], drw[1], din};
`else
    always_comb begin
        dout = '0;
        if (de) begin
            case (daddr[3:2])
                2'b00:   dout = state_w;
                2'b01:   dout = edge_w;
                2'b10:   dout = mask_w;
                default: dout = '0;
            endcase
        end
    end

    assign unused_ok = ^{ie, iaddr, daddr[31:4], daddr[1:0], drw[1], din, s2};
`endif
endmodule

// File: tb/tb_mod_switches_db.sv
// Bench for mod_switches_db: two instances (rising-edge and both-edge modes) against a sample-window model.
module tb_mod_switches_db;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ie = 1'b0, de = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, din = '0;
    logic [1:0]  drw = '0;
    logic [7:0]  sw0 = '0, sw2 = '0;
    logic [31:0] iout0, dout0, iout2, dout2;
    logic        irq0, irq2;

    int checks = 0;
    int errors = 0;

    // model: accepted state, flags, mask and the last DC+2 input samples per instance
    logic [7:0] st0, eg0, mk0, st2, eg2, mk2;
    logic [7:0] h0[$];
    logic [7:0] h2[$];

    always #5 clk = ~clk;

    mod_switches_db #(.N(8), .CNT_W(16), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr), .drw(drw),
        .din(din), .iout(iout0), .dout(dout0), .switches(sw0), .irq(irq0));

    mod_switches_db #(.N(8), .CNT_W(16), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2)) dut2 (
        .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr), .drw(drw),
        .din(din), .iout(iout2), .dout(dout2), .switches(sw2), .irq(irq2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // bits whose oldest DC synchronised samples all disagree with the accepted state
    function automatic logic [7:0] acc(input logic [7:0] q[$], input logic [7:0] s);
        logic [7:0] a = 8'hFF;
        for (int j = 0; j < DC; j++) a &= (q[j] ^ s);
        return a;
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input logic [1:0] a);
        logic [7:0] v;
        if (!de) return 32'h0;
        case (a)
            2'd0: v = (d == 0) ? st0 : st2;
            2'd1: v = (d == 0) ? eg0 : eg2;
            2'd2: v = (d == 0) ? mk0 : mk2;
`ifdef MOD_SWITCHES_DB_RAW_EN
            default: v = (d == 0) ? h0[h0.size()-2] : h2[h2.size()-2];
`else
            default: v = 8'h00;
`endif
        endcase
        return {24'h0, v};
    endfunction

    task automatic model_reset();
        st0 = 0; eg0 = 0; mk0 = 0; st2 = 0; eg2 = 0; mk2 = 0;
        h0.delete(); h2.delete();
        for (int j = 0; j < DC + 2; j++) begin h0.push_back(8'h00); h2.push_back(8'h00); end
    endtask

    task automatic model_step();
        logic [7:0] a0, a2, clr;
        logic wr;
        h0.push_back(sw0); void'(h0.pop_front());
        h2.push_back(sw2); void'(h2.pop_front());
        a0 = acc(h0, st0);
        a2 = acc(h2, st2);
        wr = de & drw[0];
        clr = (wr && daddr[3:2] == 2'd1) ? din[7:0] : 8'h00;
        eg0 = (eg0 & ~clr) | (a0 & ~st0);
        eg2 = (eg2 & ~clr) | a2;
        if (wr && daddr[3:2] == 2'd2) begin mk0 = din[7:0]; mk2 = din[7:0]; end
        st0 ^= a0;
        st2 ^= a2;
    endtask

    task automatic check_all();
        chk("dout0", dout0, exp_rd(0, daddr[3:2]));
        chk("dout2", dout2, exp_rd(2, daddr[3:2]));
        chk("irq0", {31'h0, irq0}, {31'h0, |(eg0 & mk0)});
        chk("irq2", {31'h0, irq2}, {31'h0, |(eg2 & mk2)});
        chk("iout", iout0 | iout2, 32'h0);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic idle();
        de = 0; drw = 2'b00; daddr = '0; din = '0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp0);
        de = 1; drw = 2'b10; daddr = {28'h0, a, 2'b00};
        #1;
        chk(tag, dout0, exp0);
        chk({tag, "_m"}, dout0, exp_rd(0, a));
        chk({tag, "_2"}, dout2, exp_rd(2, a));
        idle();
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
        de = 1; drw = 2'b01; daddr = {28'h0, a, 2'b00}; din = {24'h0, v};
        tick();
        idle();
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        model_reset();
        for (int a = 0; a < 4; a++) rd("rst_reg", 2'(a), 32'h0);
        chk("rst_irq", {30'h0, irq0, irq2}, 32'h0);
        chk("rst_iout", iout0 | iout2, 32'h0);
        rst = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        tick(3);

        // clean step: visible exactly DC+2 edges after the first sampling edge
        sw0 = 8'h05;
        tick(DC + 1);
        rd("step_early", 2'd0, 32'h0);
        tick();
        rd("step_state", 2'd0, 32'h05);
        rd("step_edge", 2'd1, 32'h05);

        // short pulse rejected, long pulse accepted
        sw0 = 8'h00; tick(8); wr_reg(2'd1, 8'hFF);
        sw0 = 8'h01; tick(DC - 1);
        sw0 = 8'h00; tick(8);
        rd("glitch_state", 2'd0, 32'h0);
        rd("glitch_edge", 2'd1, 32'h0);
        sw0 = 8'h01; tick(8);
        rd("hold_state", 2'd0, 32'h01);
        rd("hold_edge", 2'd1, 32'h01);

        // irq: mask, clear, new edge, W1C racing a new edge
        wr_reg(2'd1, 8'hFF);
        wr_reg(2'd2, 8'h01);
        chk("irq_masked_clr", {31'h0, irq0}, 32'h0);
        sw0 = 8'h00; tick(8); wr_reg(2'd1, 8'hFF);
        sw0 = 8'h01; tick(DC + 2);
        chk("irq_set", {31'h0, irq0}, 32'h1);
        wr_reg(2'd1, 8'h01);
        chk("irq_clr", {31'h0, irq0}, 32'h0);
        sw0 = 8'h00; tick(8); wr_reg(2'd1, 8'hFF);
        sw0 = 8'h01; tick(DC + 1);
        de = 1; drw = 2'b01; daddr = 32'h4; din = 32'h1;
        tick();
        idle();
        rd("w1c_race", 2'd1, 32'h01);

        // both-edge instance: bit3 up then down
        wr_reg(2'd1, 8'hFF);
        sw2 = 8'h08; tick(8);
        de = 1; drw = 2'b10; daddr = 32'h4; #1;
        chk("both_rise", dout2, 32'h08);
        idle();
        wr_reg(2'd1, 8'hFF);
        de = 1; drw = 2'b10; daddr = 32'h4; #1;
        chk("both_clr", dout2, 32'h00);
        idle();
        sw2 = 8'h00; tick(8);
        de = 1; drw = 2'b10; daddr = 32'h4; #1;
        chk("both_fall", dout2, 32'h08);
        idle();

        // raw register ahead of the debounced state
        sw0 = 8'hA5; tick(2);
`ifdef MOD_SWITCHES_DB_RAW_EN
        rd("raw_reg", 2'd3, 32'hA5);
`else
        rd("raw_reg", 2'd3, 32'h00);
`endif
        rd("raw_state", 2'd0, 32'h01);
        wr_reg(2'd0, 8'hFF);
        wr_reg(2'd3, 8'hFF);

        // randomized traffic, including resets mid-count with inputs held high
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 5) == 0) sw0 = 8'($urandom);
            if ($urandom_range(0, 5) == 0) sw2 = 8'($urandom);
            de    = 1'($urandom);
            drw   = {1'($urandom), ($urandom_range(0, 3) == 0)};
            daddr = $urandom;
            din   = $urandom;
            iaddr = $urandom;
            ie    = 1'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                idle();
                do_reset();
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
